hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It consumes the ID-stage register indices and the EX-stage control outputs of the ID/EX pipeline register. It drives the stall, bubble, flush and freeze controls back into PC, IF/ID and ID/EX. A small FSM tracks data-memory wait periods and enforces a memory-timeout error state.

---
 rtl/hazard_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// ============================================================================
// Module      : hazard_if
// Description : Bundle of the hazard-controller inputs (ID register indices,
//               EX control outputs, memory busy) and the pipeline controls it
//               drives back into PC, IF/ID and ID/EX.
//               master : pipeline side (drives indices/status, takes controls)
//               slave  : hazard controller (takes indices/status, drives controls)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_if;
    logic [4:0] id_readReg1;
    logic [4:0] id_readReg2;
    logic       id_usesReg2;
    logic       ex_memRead;
    logic [4:0] ex_writeReg;
    logic       ex_branchTaken;
    logic       mem_busy;

    logic       pcWrite;
    logic       ifidWrite;
    logic       ifidFlush;
    logic       idexBubble;
    logic       pipeFreeze;
    logic       memTimeout;
    logic [1:0] hzState;

    modport master (
        output id_readReg1, id_readReg2, id_usesReg2,
        output ex_memRead, ex_writeReg, ex_branchTaken, mem_busy,
        input  pcWrite, ifidWrite, ifidFlush, idexBubble,
        input  pipeFreeze, memTimeout, hzState
    );

    modport slave (
        input  id_readReg1, id_readReg2, id_usesReg2,
        input  ex_memRead, ex_writeReg, ex_branchTaken, mem_busy,
        output pcWrite, ifidWrite, ifidFlush, idexBubble,
        output pipeFreeze, memTimeout, hzState
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage RISC-V core.
//               Detects load-use hazards and taken branches, freezes the
//               pipeline while data memory is busy and latches a sticky
//               timeout error when the memory stays busy too long.
//               Optional macro HAZARD_PERF_EN adds saturating performance
//               counters (luStalls, flushes, freezeCycles).
// Ports       : clk    - core clock, rising edge
//               rst_n  - asynchronous active-low reset
//               hz     - hazard_if.slave (ID/EX inputs, pipeline controls)
//               luStalls/flushes/freezeCycles - perf counters (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16,
    parameter int CW      = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_if.slave            hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CW-1:0]      luStalls,
    output logic [CW-1:0]      flushes,
    output logic [CW-1:0]      freezeCycles
`endif
);

    // Reject configurations the wait counter and datapath cannot represent.
    generate
        if (TIMEOUT < 1 || TIMEOUT > 255 || N < 1 || CW < 1) begin : g_bad_param
            $error("hazard_ctrl: illegal parameter value");
        end
    endgenerate

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_q,  wait_d;

    logic w_lu;
    logic w_pcWrite, w_ifidWrite, w_ifidFlush, w_idexBubble;
    logic w_pipeFreeze, w_memTimeout;

    // Load-use: a load in EX writes a register the ID instruction reads.
    // x0 never creates a dependency; rs2 only counts when actually read.
    assign w_lu = hz.ex_memRead && (hz.ex_writeReg != 5'd0) &&
                  ((hz.ex_writeReg == hz.id_readReg1) ||
                   (hz.id_usesReg2 && (hz.ex_writeReg == hz.id_readReg2)));

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        w_pcWrite    = 1'b1;
        w_ifidWrite  = 1'b1;
        w_ifidFlush  = 1'b0;
        w_idexBubble = 1'b0;
        w_pipeFreeze = 1'b0;
        w_memTimeout = 1'b0;

        case (state_q)
            RUN, MEM_WAIT: begin
                if (hz.mem_busy) begin
                    // Freeze wins; branch/LU are re-presented after the hold.
                    w_pcWrite    = 1'b0;
                    w_ifidWrite  = 1'b0;
                    w_pipeFreeze = 1'b1;
                    wait_d       = (state_q == RUN) ? 8'd1 : wait_q + 8'd1;
                    state_d      = (wait_d >= c_TIMEOUT) ? ERROR : MEM_WAIT;
                end else begin
                    // Leaving MEM_WAIT decodes exactly like RUN this cycle.
                    if (hz.ex_branchTaken) begin
                        w_ifidFlush  = 1'b1;
                        w_idexBubble = 1'b1;
                    end else if (w_lu) begin
                        w_pcWrite    = 1'b0;
                        w_ifidWrite  = 1'b0;
                        w_idexBubble = 1'b1;
                    end
                    state_d = RUN;
                    wait_d  = 8'd0;
                end
            end
            default: begin
                // ERROR (and any unreachable code) holds until reset.
                w_pcWrite    = 1'b0;
                w_ifidWrite  = 1'b0;
                w_pipeFreeze = 1'b1;
                w_memTimeout = 1'b1;
                state_d      = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign hz.pcWrite    = w_pcWrite;
    assign hz.ifidWrite  = w_ifidWrite;
    assign hz.ifidFlush  = w_ifidFlush;
    assign hz.idexBubble = w_idexBubble;
    assign hz.pipeFreeze = w_pipeFreeze;
    assign hz.memTimeout = w_memTimeout;
    assign hz.hzState    = state_q;

`ifdef HAZARD_PERF_EN
    logic [CW-1:0] luStalls_q, flushes_q, freezeCycles_q;
    logic          w_luStall;

    // A bubble without a flush is a load-use stall.
    assign w_luStall = w_idexBubble && !w_ifidFlush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luStalls_q     <= '0;
            flushes_q      <= '0;
            freezeCycles_q <= '0;
        end else begin
            if (w_luStall && (luStalls_q != '1))
                luStalls_q <= luStalls_q + 1'b1;
            if (w_ifidFlush && (flushes_q != '1))
                flushes_q <= flushes_q + 1'b1;
            if (w_pipeFreeze && (freezeCycles_q != '1))
                freezeCycles_q <= freezeCycles_q + 1'b1;
        end
    end

    assign luStalls     = luStalls_q;
    assign flushes      = flushes_q;
    assign freezeCycles = freezeCycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl. Stimulus pushes the hand-
//               computed control vector {pcWrite, ifidWrite, ifidFlush,
//               idexBubble, pipeFreeze, memTimeout, hzState} for each cycle;
//               a monitor pops and compares at the falling edge.
//               With HAZARD_PERF_EN defined, luStalls saturation is checked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    localparam int TB_TIMEOUT = 4;
    localparam int TB_CW      = 2;

    // Expected vectors: [7]pc [6]ifid [5]flush [4]bubble [3]freeze [2]timeout [1:0]state
    localparam logic [7:0] V_NORM  = 8'b1100_0000;
    localparam logic [7:0] V_LU    = 8'b0001_0000;
    localparam logic [7:0] V_FLUSH = 8'b1111_0000;
    localparam logic [7:0] V_FRZ   = 8'b0000_1000;
    localparam logic [7:0] V_ERR   = 8'b0000_1110;
    localparam logic [7:0] S_WAIT  = 8'b0000_0001;

    logic clk;
    logic rst_n;
    hazard_if hz ();

`ifdef HAZARD_PERF_EN
    logic [TB_CW-1:0] luStalls, flushes, freezeCycles;
`endif

    hazard_ctrl #(.N(32), .TIMEOUT(TB_TIMEOUT), .CW(TB_CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hz           (hz.slave)
`ifdef HAZARD_PERF_EN
        ,
        .luStalls     (luStalls),
        .flushes      (flushes),
        .freezeCycles (freezeCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [7:0]       exp;
        bit               chk_perf;
        logic [TB_CW-1:0] exp_lu;
    } item_t;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Monitor: one expected vector per cycle, compared mid-cycle.
    initial begin
        item_t       it;
        logic  [7:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {hz.pcWrite, hz.ifidWrite, hz.ifidFlush, hz.idexBubble,
                       hz.pipeFreeze, hz.memTimeout, hz.hzState};
                n_cmp++;
                if (act !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
                end
`ifdef HAZARD_PERF_EN
                if (it.chk_perf) begin
                    n_cmp++;
                    if (luStalls !== it.exp_lu) begin
                        n_bad++;
                        $display("FAIL %s_luStalls: got %0d expected %0d",
                                 it.name, luStalls, it.exp_lu);
                    end
                end
`endif
            end
        end
    end

    task automatic push(input string name, input logic [7:0] exp,
                        input bit chk_perf, input logic [TB_CW-1:0] exp_lu);
        item_t it;
        it.name     = name;
        it.exp      = exp;
        it.chk_perf = chk_perf;
        it.exp_lu   = exp_lu;
        sb.push_back(it);
    endtask

    task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u2, input logic br,
                         input logic busy);
        hz.ex_memRead     = mr;
        hz.ex_writeReg    = wr;
        hz.id_readReg1    = r1;
        hz.id_readReg2    = r2;
        hz.id_usesReg2    = u2;
        hz.ex_branchTaken = br;
        hz.mem_busy       = busy;
    endtask

    // One cycle: inputs applied just after the rising edge, reset released.
    task automatic step(input string name, input logic mr, input logic [4:0] wr,
                        input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                        input logic br, input logic busy, input logic [7:0] exp,
                        input bit chk_perf = 1'b0, input logic [TB_CW-1:0] exp_lu = '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(mr, wr, r1, r2, u2, br, busy);
        push(name, exp, chk_perf, exp_lu);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        push("reset", V_NORM, 1'b0, '0);

        //    name             mr  wr     r1     r2     u2  br  busy exp
        step("lu_rs1",        1, 5'd5, 5'd5, 5'd0, 0, 0, 0, V_LU);
        step("lu_released",   0, 5'd5, 5'd5, 5'd0, 0, 0, 0, V_NORM);
        step("x0_no_stall",   1, 5'd0, 5'd0, 5'd0, 0, 0, 0, V_NORM);
        step("rs2_unused",    1, 5'd7, 5'd3, 5'd7, 0, 0, 0, V_NORM);
        step("lu_rs2",        1, 5'd7, 5'd3, 5'd7, 1, 0, 0, V_LU);
        step("branch_over_lu",1, 5'd7, 5'd3, 5'd7, 1, 1, 0, V_FLUSH);
        step("branch_only",   0, 5'd0, 5'd0, 5'd0, 0, 1, 0, V_FLUSH);

        // Three busy cycles with a pending branch, released into a flush.
        step("busy1_run",     0, 5'd0, 5'd0, 5'd0, 0, 1, 1, V_FRZ);
        step("busy2_wait",    1, 5'd4, 5'd4, 5'd0, 0, 1, 1, V_FRZ | S_WAIT);
        step("busy3_wait",    0, 5'd0, 5'd0, 5'd0, 0, 1, 1, V_FRZ | S_WAIT);
        step("wait_exit_br",  0, 5'd0, 5'd0, 5'd0, 0, 1, 0, V_FLUSH | S_WAIT);
        step("back_to_run",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, V_NORM);

        // A held load-use takes effect in the cycle MEM_WAIT is left.
        step("busy_short",    1, 5'd9, 5'd9, 5'd0, 0, 0, 1, V_FRZ);
        step("wait_exit_lu",  1, 5'd9, 5'd9, 5'd0, 0, 0, 0, V_LU | S_WAIT);
        step("lu_cleared",    0, 5'd9, 5'd9, 5'd0, 0, 0, 0, V_NORM);

        // Timeout: busy for TIMEOUT cycles ends in sticky ERROR.
        step("to_busy1",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1, V_FRZ);
        step("to_busy2",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1, V_FRZ | S_WAIT);
        step("to_busy3",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1, V_FRZ | S_WAIT);
        step("to_busy4",      0, 5'd0, 5'd0, 5'd0, 0, 0, 1, V_FRZ | S_WAIT);
        step("error_entered", 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, V_ERR);
        step("error_sticky",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, V_ERR);
        step("error_held",    0, 5'd0, 5'd0, 5'd0, 0, 1, 0, V_ERR);

        // Asynchronous reset between edges clears ERROR before the next edge.
        @(posedge clk);
        #2;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        push("async_reset", V_NORM, 1'b0, '0);

        // Five load-use cycles; a 2-bit counter saturates at 3.
        step("perf_lu1",      1, 5'd6, 5'd6, 5'd0, 0, 0, 0, V_LU, 1'b1, 2'd0);
        step("perf_lu2",      1, 5'd6, 5'd6, 5'd0, 0, 0, 0, V_LU);
        step("perf_lu3",      1, 5'd6, 5'd6, 5'd0, 0, 0, 0, V_LU, 1'b1, 2'd2);
        step("perf_lu4",      1, 5'd6, 5'd6, 5'd0, 0, 0, 0, V_LU);
        step("perf_lu5",      1, 5'd6, 5'd6, 5'd0, 0, 0, 0, V_LU);
        step("perf_sat",      0, 5'd0, 5'd0, 5'd0, 0, 0, 0, V_NORM, 1'b1, 2'd3);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
